// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e  - frame FSM encodings (4-bit): IDLE, START, DATA, PARITY, STOP
//   clks_per_bit  - system clocks per serial bit (integer division)
package uart_pkg;
   typedef enum logic [3:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
   function automatic int clks_per_bit(input int clk_freq, input int b_rate);
      return clk_freq / b_rate;
   endfunction
endpackage

// File: rtl/uart_xmit_if.sv
// uart_xmit_if: byte-request / serial-line bundle of the UART transmitter.
//   T_EN          - transmit request (master -> slave)
//   Data          - byte to send, valid with T_EN (master -> slave)
//   Serial        - TX line, idle high (slave -> master)
//   Busy          - frame in progress (slave -> master)
//   Transmit_Done - one-cycle end-of-frame pulse (slave -> master)
interface uart_xmit_if;
   logic       T_EN;
   logic [7:0] Data;
   logic       Serial;
   logic       Busy;
   logic       Transmit_Done;
   modport master (output T_EN, Data, input Serial, Busy, Transmit_Done);
   modport slave (input T_EN, Data, output Serial, Busy, Transmit_Done);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with clear; bit_tick_o is high in the last cycle of each bit.
//   Clk, reset  - clock, synchronous active-high reset
//   clr_i       - holds the counter at zero (used while the transmitter is idle)
//   bit_tick_o  - one-cycle pulse every CLKS_PER_BIT cycles
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic Clk,
   input  logic reset,
   input  logic clr_i,
   output logic bit_tick_o
);
   logic [31:0] cnt_q;
   assign bit_tick_o = (cnt_q == 32'(CLKS_PER_BIT - 1));
   // Wrapping on the tick restarts the count exactly at each bit boundary.
   always_ff @(posedge Clk) begin
      if (reset || clr_i || bit_tick_o) cnt_q <= '0;
      else cnt_q <= cnt_q + 32'd1;
   end
endmodule

// File: rtl/uart_xmit.sv
// uart_xmit: UART transmitter, one byte per T_EN as 8N1/8N2, or 8E1/8E2 when UART_XMIT_PARITY_EN is defined.
//   Clk, reset - clock, synchronous active-high reset (aborts any frame)
//   bus        - uart_xmit_if.slave: T_EN/Data in, Serial/Busy/Transmit_Done out
module uart_xmit
   import uart_pkg::*;
#(
   parameter int ClkFreq   = 50000000,
   parameter int B_Rate    = 9600,
   parameter int STOP_BITS = 1
) (
   input logic         Clk,
   input logic         reset,
   uart_xmit_if.slave  bus
);
   localparam int CLKS_PER_BIT = clks_per_bit(ClkFreq, B_Rate);
   uart_state_e state_q;
   logic [7:0]  shift_q;
   logic [2:0]  bit_idx_q;
   logic        stop_cnt_q;
   logic        serial_q, busy_q, done_q;
   logic        tick;
`ifdef UART_XMIT_PARITY_EN
   logic        parity_q;
`endif
   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .Clk(Clk),
      .reset(reset),
      .clr_i(state_q == IDLE),
      .bit_tick_o(tick)
   );
   assign bus.Serial = serial_q;
   assign bus.Busy = busy_q;
   assign bus.Transmit_Done = done_q;
   // Serial always carries the bit of the current slot; each tick loads the next one.
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_idx_q <= '0;
         stop_cnt_q <= 1'b0;
         serial_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef UART_XMIT_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.T_EN && !busy_q) begin
               state_q <= START;
               shift_q <= bus.Data;
               bit_idx_q <= '0;
               serial_q <= 1'b0;
               busy_q <= 1'b1;
`ifdef UART_XMIT_PARITY_EN
               parity_q <= ^bus.Data;
`endif
            end
            START: if (tick) begin
               state_q <= DATA;
               serial_q <= shift_q[0];
               shift_q <= shift_q >> 1;
            end
            DATA: if (tick) begin
               bit_idx_q <= bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_XMIT_PARITY_EN
                  state_q <= PARITY;
                  serial_q <= parity_q;
`else
                  state_q <= STOP;
                  serial_q <= 1'b1;
                  stop_cnt_q <= 1'b0;
`endif
               end else begin
                  serial_q <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
`ifdef UART_XMIT_PARITY_EN
            PARITY: if (tick) begin
               state_q <= STOP;
               serial_q <= 1'b1;
               stop_cnt_q <= 1'b0;
            end
`endif
            STOP: if (tick) begin
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  state_q <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else stop_cnt_q <= stop_cnt_q + 1'b1;
            end
            default: begin
               state_q <= IDLE;
               serial_q <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
